// File: rtl/tlb_array.sv
// Fully associative joint TLB. Entry storage, two registered search ports
// (fetch and data), a combinational TLBP probe and a combinational indexed read.
// After reset a clear sequencer invalidates one entry per cycle before the
// array starts answering lookups.
//
// state | meaning
// CLEAR | sweeping entries, invalidating entry clr_cnt each cycle; lookups forced to miss
// RUN   | normal operation; writes and lookups serviced
module tlb_array #(
    parameter int TLBNUM       = 16,
    parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    ready,

    input  logic                    we,
    input  logic [TLBNUM_WIDTH-1:0] w_index,
    input  logic [18:0]             w_vpn2,
    input  logic [7:0]              w_asid,
    input  logic                    w_g,
    input  logic [19:0]             w_pfn0,
    input  logic [2:0]              w_c0,
    input  logic                    w_d0,
    input  logic                    w_v0,
    input  logic [19:0]             w_pfn1,
    input  logic [2:0]              w_c1,
    input  logic                    w_d1,
    input  logic                    w_v1,

    input  logic [TLBNUM_WIDTH-1:0] r_index,
    output logic [18:0]             r_vpn2,
    output logic [7:0]              r_asid,
    output logic                    r_g,
    output logic [19:0]             r_pfn0,
    output logic [2:0]              r_c0,
    output logic                    r_d0,
    output logic                    r_v0,
    output logic [19:0]             r_pfn1,
    output logic [2:0]              r_c1,
    output logic                    r_d1,
    output logic                    r_v1,

    input  logic                    s0_req,
    input  logic [18:0]             s0_vpn2,
    input  logic                    s0_odd,
    input  logic [7:0]              s0_asid,
    output logic                    s0_found,
    output logic [TLBNUM_WIDTH-1:0] s0_index,
    output logic [19:0]             s0_pfn,
    output logic [2:0]              s0_c,
    output logic                    s0_d,
    output logic                    s0_v,

    input  logic                    s1_req,
    input  logic [18:0]             s1_vpn2,
    input  logic                    s1_odd,
    input  logic [7:0]              s1_asid,
    output logic                    s1_found,
    output logic [TLBNUM_WIDTH-1:0] s1_index,
    output logic [19:0]             s1_pfn,
    output logic [2:0]              s1_c,
    output logic                    s1_d,
    output logic                    s1_v,

    input  logic [18:0]             p_vpn2,
    input  logic [7:0]              p_asid,
    output logic [TLBNUM_WIDTH:0]   p_result
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t                  state, state_nx;
    logic [TLBNUM_WIDTH:0]   clr_cnt, clr_cnt_nx;

    logic [18:0] tlb_vpn2 [TLBNUM];
    logic [7:0]  tlb_asid [TLBNUM];
    logic        tlb_g    [TLBNUM];
    logic [19:0] tlb_pfn0 [TLBNUM];
    logic [2:0]  tlb_c0   [TLBNUM];
    logic        tlb_d0   [TLBNUM];
    logic        tlb_v0   [TLBNUM];
    logic [19:0] tlb_pfn1 [TLBNUM];
    logic [2:0]  tlb_c1   [TLBNUM];
    logic        tlb_d1   [TLBNUM];
    logic        tlb_v1   [TLBNUM];

    // Priority lookup: returns {hit, index}, lowest matching index wins.
    function automatic logic [TLBNUM_WIDTH:0] find(input logic [18:0] key_vpn2,
                                                   input logic [7:0]  key_asid);
        logic                    hit;
        logic [TLBNUM_WIDTH-1:0] idx;
        hit = 1'b0;
        idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (tlb_vpn2[i] == key_vpn2 && (tlb_g[i] || tlb_asid[i] == key_asid)) begin
                hit = 1'b1;
                idx = TLBNUM_WIDTH'(i);
            end
        end
        return {hit, idx};
    endfunction

    // Clear sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    // Clear sequencer next state: advance one entry per cycle, leave on the last one.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_nx = clr_cnt + (TLBNUM_WIDTH + 1)'(1);
            if (clr_cnt == (TLBNUM_WIDTH + 1)'(TLBNUM - 1))
                state_nx = RUN;
        end
    end

    assign ready = (state == RUN);

    // Entry storage: sweep invalidation while clearing, CP0 writes once running.
    // The key is zeroed too so stale keys cannot hit an invalidated entry.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            tlb_vpn2[clr_cnt[TLBNUM_WIDTH-1:0]] <= '0;
            tlb_asid[clr_cnt[TLBNUM_WIDTH-1:0]] <= '0;
            tlb_g[clr_cnt[TLBNUM_WIDTH-1:0]]    <= 1'b0;
            tlb_v0[clr_cnt[TLBNUM_WIDTH-1:0]]   <= 1'b0;
            tlb_v1[clr_cnt[TLBNUM_WIDTH-1:0]]   <= 1'b0;
        end else if (we && !reset) begin
            tlb_vpn2[w_index] <= w_vpn2;
            tlb_asid[w_index] <= w_asid;
            tlb_g[w_index]    <= w_g;
            tlb_pfn0[w_index] <= w_pfn0;
            tlb_c0[w_index]   <= w_c0;
            tlb_d0[w_index]   <= w_d0;
            tlb_v0[w_index]   <= w_v0;
            tlb_pfn1[w_index] <= w_pfn1;
            tlb_c1[w_index]   <= w_c1;
            tlb_d1[w_index]   <= w_d1;
            tlb_v1[w_index]   <= w_v1;
        end
    end

    logic [TLBNUM_WIDTH:0] s0_lk, s1_lk, p_lk;
    logic [TLBNUM_WIDTH-1:0] s0_i, s1_i;
    logic [19:0] s0_pfn_nx, s1_pfn_nx;
    logic [2:0]  s0_c_nx, s1_c_nx;
    logic        s0_d_nx, s1_d_nx, s0_v_nx, s1_v_nx;

    // Combinational lookups and odd/even page select; a miss yields all-zero fields.
    always_comb begin
        s0_lk = find(s0_vpn2, s0_asid);
        s1_lk = find(s1_vpn2, s1_asid);
        p_lk  = find(p_vpn2, p_asid);
        s0_i  = s0_lk[TLBNUM_WIDTH-1:0];
        s1_i  = s1_lk[TLBNUM_WIDTH-1:0];
        s0_pfn_nx = '0; s0_c_nx = '0; s0_d_nx = 1'b0; s0_v_nx = 1'b0;
        s1_pfn_nx = '0; s1_c_nx = '0; s1_d_nx = 1'b0; s1_v_nx = 1'b0;
        if (s0_lk[TLBNUM_WIDTH]) begin
            s0_pfn_nx = s0_odd ? tlb_pfn1[s0_i] : tlb_pfn0[s0_i];
            s0_c_nx   = s0_odd ? tlb_c1[s0_i]   : tlb_c0[s0_i];
            s0_d_nx   = s0_odd ? tlb_d1[s0_i]   : tlb_d0[s0_i];
            s0_v_nx   = s0_odd ? tlb_v1[s0_i]   : tlb_v0[s0_i];
        end
        if (s1_lk[TLBNUM_WIDTH]) begin
            s1_pfn_nx = s1_odd ? tlb_pfn1[s1_i] : tlb_pfn0[s1_i];
            s1_c_nx   = s1_odd ? tlb_c1[s1_i]   : tlb_c0[s1_i];
            s1_d_nx   = s1_odd ? tlb_d1[s1_i]   : tlb_d0[s1_i];
            s1_v_nx   = s1_odd ? tlb_v1[s1_i]   : tlb_v0[s1_i];
        end
    end

    // Registered search results; held when no request, forced to miss while clearing.
    always_ff @(posedge clk) begin
        if (reset || state == CLEAR) begin
            s0_found <= 1'b0; s0_index <= '0; s0_pfn <= '0; s0_c <= '0; s0_d <= 1'b0; s0_v <= 1'b0;
            s1_found <= 1'b0; s1_index <= '0; s1_pfn <= '0; s1_c <= '0; s1_d <= 1'b0; s1_v <= 1'b0;
        end else begin
            if (s0_req) begin
                s0_found <= s0_lk[TLBNUM_WIDTH];
                s0_index <= s0_lk[TLBNUM_WIDTH] ? s0_i : '0;
                s0_pfn   <= s0_pfn_nx;
                s0_c     <= s0_c_nx;
                s0_d     <= s0_d_nx;
                s0_v     <= s0_v_nx;
            end
            if (s1_req) begin
                s1_found <= s1_lk[TLBNUM_WIDTH];
                s1_index <= s1_lk[TLBNUM_WIDTH] ? s1_i : '0;
                s1_pfn   <= s1_pfn_nx;
                s1_c     <= s1_c_nx;
                s1_d     <= s1_d_nx;
                s1_v     <= s1_v_nx;
            end
        end
    end

    assign p_result = {~p_lk[TLBNUM_WIDTH] | ~ready, p_lk[TLBNUM_WIDTH-1:0]};

    assign r_vpn2 = tlb_vpn2[r_index];
    assign r_asid = tlb_asid[r_index];
    assign r_g    = tlb_g[r_index];
    assign r_pfn0 = tlb_pfn0[r_index];
    assign r_c0   = tlb_c0[r_index];
    assign r_d0   = tlb_d0[r_index];
    assign r_v0   = tlb_v0[r_index];
    assign r_pfn1 = tlb_pfn1[r_index];
    assign r_c1   = tlb_c1[r_index];
    assign r_d1   = tlb_d1[r_index];
    assign r_v1   = tlb_v1[r_index];

endmodule

// File: tb/tb_tlb_array.sv
// Bench for tlb_array: a queue scoreboard for the two search ports, a
// behavioural entry table as reference, combinational probe/read checks.
module tb_tlb_array;

    logic clk = 1'b0, reset;
    logic ready;
    logic we;
    logic [3:0] w_index, r_index;
    logic [18:0] w_vpn2, r_vpn2, s0_vpn2, s1_vpn2, p_vpn2;
    logic [7:0] w_asid, r_asid, s0_asid, s1_asid, p_asid;
    logic w_g, r_g;
    logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1, s0_pfn, s1_pfn;
    logic [2:0] w_c0, w_c1, r_c0, r_c1, s0_c, s1_c;
    logic w_d0, w_d1, w_v0, w_v1, r_d0, r_d1, r_v0, r_v1;
    logic s0_req, s1_req, s0_odd, s1_odd;
    logic s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
    logic [3:0] s0_index, s1_index;
    logic [4:0] p_result;

    tlb_array #(.TLBNUM(16)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd(s0_odd), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd(s1_odd), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .p_vpn2(p_vpn2), .p_asid(p_asid), .p_result(p_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic found; logic [3:0] idx; logic [19:0] pfn; logic [2:0] c; logic d; logic v; bit full;
    } exp_t;

    exp_t q0[$], q1[$];
    exp_t last0, last1;
    int n_cmp = 0, n_bad = 0;
    int since_rst = 0;

    // Reference table
    logic [18:0] m_vpn2 [16];
    logic [7:0]  m_asid [16];
    logic        m_g [16], m_d0 [16], m_v0 [16], m_d1 [16], m_v1 [16];
    logic [19:0] m_pfn0 [16], m_pfn1 [16];
    logic [2:0]  m_c0 [16], m_c1 [16];
    bit          m_known [16];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0;
            m_v0[i] = 1'b0; m_v1[i] = 1'b0; m_known[i] = 1'b0;
        end
    endfunction

    function automatic int model_probe(logic [18:0] vpn, logic [7:0] asid);
        for (int i = 0; i < 16; i++)
            if (m_vpn2[i] == vpn && (m_g[i] || m_asid[i] == asid)) return i;
        return -1;
    endfunction

    function automatic exp_t model_lookup(logic [18:0] vpn, logic [7:0] asid, logic odd);
        exp_t e;
        int k;
        e = '{found: 1'b0, idx: 4'd0, pfn: 20'd0, c: 3'd0, d: 1'b0, v: 1'b0, full: 1'b1};
        k = model_probe(vpn, asid);
        if (k >= 0) begin
            e.found = 1'b1;
            e.idx = 4'(k);
            e.pfn = odd ? m_pfn1[k] : m_pfn0[k];
            e.c   = odd ? m_c1[k]   : m_c0[k];
            e.d   = odd ? m_d1[k]   : m_d0[k];
            e.v   = odd ? m_v1[k]   : m_v0[k];
        end
        return e;
    endfunction

    function automatic logic [18:0] pick_vpn();
        case ($urandom_range(0, 3))
            0: return 19'h12345;
            1: return 19'h2AAAA;
            2: return 19'h00001;
            default: return 19'h7ABCD;
        endcase
    endfunction

    function automatic logic [7:0] pick_asid();
        case ($urandom_range(0, 3))
            0: return 8'h07;
            1: return 8'h08;
            2: return 8'h33;
            default: return 8'h10;
        endcase
    endfunction

    task automatic idle();
        we = 1'b0; s0_req = 1'b0; s1_req = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [18:0] vpn, input logic [7:0] asid, input logic g,
                      input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                      input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        we = 1'b1; w_index = 4'(idx); w_vpn2 = vpn; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    endtask

    // One cycle: inputs already set just after a negedge; returns at the next negedge.
    task automatic step();
        exp_t e0, e1;
        int pi;
        bit clearing;
        #1;
        if (!reset) begin
            chk("ready", 32'(ready), 32'(since_rst >= 16));
            if (since_rst < 16) begin
                chk("p_msb_clear", 32'(p_result[4]), 32'd1);
            end else begin
                pi = model_probe(p_vpn2, p_asid);
                if (pi >= 0) chk("p_result", 32'(p_result), {27'd0, 1'b0, 4'(pi)});
                else chk("p_miss", 32'(p_result[4]), 32'd1);
                chk("r_g", 32'(r_g), 32'(m_g[r_index]));
                chk("r_v0", 32'(r_v0), 32'(m_v0[r_index]));
                chk("r_v1", 32'(r_v1), 32'(m_v1[r_index]));
                if (m_known[r_index]) begin
                    chk("r_vpn2", 32'(r_vpn2), 32'(m_vpn2[r_index]));
                    chk("r_asid", 32'(r_asid), 32'(m_asid[r_index]));
                    chk("r_pfn0", 32'(r_pfn0), 32'(m_pfn0[r_index]));
                    chk("r_pfn1", 32'(r_pfn1), 32'(m_pfn1[r_index]));
                    chk("r_cd", {24'd0, r_c0, r_d0, r_c1, r_d1}, {24'd0, m_c0[r_index], m_d0[r_index], m_c1[r_index], m_d1[r_index]});
                end
            end
        end
        clearing = reset || since_rst < 16;
        if (clearing) begin
            last0 = '{found: 1'b0, idx: 4'd0, pfn: 20'd0, c: 3'd0, d: 1'b0, v: 1'b0, full: 1'b1};
            last1 = last0;
            e0 = last0; e1 = last0;
            e0.full = reset; e1.full = reset;
        end else begin
            if (s0_req) last0 = model_lookup(s0_vpn2, s0_asid, s0_odd);
            if (s1_req) last1 = model_lookup(s1_vpn2, s1_asid, s1_odd);
            e0 = last0; e1 = last1;
            if (we) begin
                m_vpn2[w_index] = w_vpn2; m_asid[w_index] = w_asid; m_g[w_index] = w_g;
                m_pfn0[w_index] = w_pfn0; m_c0[w_index] = w_c0; m_d0[w_index] = w_d0; m_v0[w_index] = w_v0;
                m_pfn1[w_index] = w_pfn1; m_c1[w_index] = w_c1; m_d1[w_index] = w_d1; m_v1[w_index] = w_v1;
                m_known[w_index] = 1'b1;
            end
        end
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        if (reset) since_rst = 0;
        else if (since_rst < 16) begin
            since_rst++;
            if (since_rst == 16) model_clear();
        end
        @(negedge clk);
    endtask

    // Monitor: after every active edge, compare registered search outputs with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("s0_found", 32'(s0_found), 32'(e.found));
                if (e.full) begin
                    chk("s0_index", 32'(s0_index), 32'(e.idx));
                    chk("s0_page", {8'd0, s0_pfn, s0_c, s0_d}, {8'd0, e.pfn, e.c, e.d});
                    chk("s0_v", 32'(s0_v), 32'(e.v));
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("s1_found", 32'(s1_found), 32'(e.found));
                if (e.full) begin
                    chk("s1_index", 32'(s1_index), 32'(e.idx));
                    chk("s1_page", {8'd0, s1_pfn, s1_c, s1_d}, {8'd0, e.pfn, e.c, e.d});
                    chk("s1_v", 32'(s1_v), 32'(e.v));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic rand_inputs(input bit allow_we);
        we = allow_we && ($urandom_range(0, 2) == 0);
        w_index = 4'($urandom_range(0, 15));
        w_vpn2 = pick_vpn(); w_asid = pick_asid(); w_g = ($urandom_range(0, 3) == 0);
        w_pfn0 = 20'($urandom); w_c0 = 3'($urandom); w_d0 = 1'($urandom); w_v0 = 1'($urandom);
        w_pfn1 = 20'($urandom); w_c1 = 3'($urandom); w_d1 = 1'($urandom); w_v1 = 1'($urandom);
        r_index = 4'($urandom_range(0, 15));
        s0_req = 1'($urandom); s0_vpn2 = pick_vpn(); s0_asid = pick_asid(); s0_odd = 1'($urandom);
        s1_req = 1'($urandom); s1_vpn2 = pick_vpn(); s1_asid = pick_asid(); s1_odd = 1'($urandom);
        p_vpn2 = pick_vpn(); p_asid = pick_asid();
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        rand_inputs(1'b0);
        idle();
        @(negedge clk);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rand_inputs(1'b1);
            step();
        end
        chk("ready_after_sweep", 32'(ready), 32'd1);

        idle();
        wr(5, 19'h12345, 8'h07, 1'b0, 20'hABCDE, 3'd0, 1'b0, 1'b1, 20'h11111, 3'd3, 1'b0, 1'b1);
        step();
        idle();
        s0_req = 1'b1; s0_vpn2 = 19'h12345; s0_odd = 1'b1; s0_asid = 8'h07;
        step();
        chk("dir_s0_found", 32'(s0_found), 32'd1);
        chk("dir_s0_index", 32'(s0_index), 32'd5);
        chk("dir_s0_pfn", 32'(s0_pfn), 32'h11111);
        chk("dir_s0_c", 32'(s0_c), 32'd3);
        chk("dir_s0_v", 32'(s0_v), 32'd1);
        s0_asid = 8'h08;
        step();
        chk("dir_asid_miss", 32'(s0_found), 32'd0);
        idle();
        wr(5, 19'h12345, 8'h07, 1'b1, 20'hABCDE, 3'd0, 1'b0, 1'b1, 20'h11111, 3'd3, 1'b0, 1'b1);
        step();
        idle();
        s0_req = 1'b1; s0_vpn2 = 19'h12345; s0_odd = 1'b1; s0_asid = 8'h08;
        p_vpn2 = 19'h12345; p_asid = 8'h08;
        step();
        chk("dir_global_hit", 32'(s0_found), 32'd1);
        chk("dir_probe5", 32'(p_result), 32'h05);

        idle();
        wr(2, 19'h2AAAA, 8'h33, 1'b0, 20'h22222, 3'd2, 1'b1, 1'b1, 20'h33333, 3'd1, 1'b0, 1'b0);
        step();
        wr(9, 19'h2AAAA, 8'h33, 1'b0, 20'h99999, 3'd5, 1'b0, 1'b1, 20'h88888, 3'd6, 1'b1, 1'b1);
        step();
        idle();
        s1_req = 1'b1; s1_vpn2 = 19'h2AAAA; s1_asid = 8'h33; s1_odd = 1'b0;
        p_vpn2 = 19'h2AAAA; p_asid = 8'h33;
        step();
        chk("dir_prio_s1", 32'(s1_index), 32'd2);
        chk("dir_prio_p", 32'(p_result), 32'h02);

        idle();
        wr(3, 19'h00001, 8'h10, 1'b0, 20'h30303, 3'd4, 1'b1, 1'b1, 20'h40404, 3'd7, 1'b1, 1'b1);
        s1_req = 1'b1; s1_vpn2 = 19'h00001; s1_asid = 8'h10; s1_odd = 1'b1;
        step();
        chk("dir_rbw_miss", 32'(s1_found), 32'd0);
        we = 1'b0;
        step();
        chk("dir_rbw_hit", 32'(s1_found), 32'd1);
        chk("dir_rbw_index", 32'(s1_index), 32'd3);

        for (int n = 0; n < 300; n++) begin
            rand_inputs(1'b1);
            step();
        end

        idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_inputs(1'b1);
            step();
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rand_inputs(1'b1);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            idle();
            r_index = 4'(i);
            p_vpn2 = pick_vpn(); p_asid = pick_asid();
            s0_req = 1'b1; s0_vpn2 = pick_vpn(); s0_asid = pick_asid(); s0_odd = 1'($urandom);
            step();
            chk("sweep_p_miss", 32'(p_result[4]), 32'd1);
            chk("sweep_s0_miss", 32'(s0_found), 32'd0);
            chk("sweep_rv", {30'd0, r_v0, r_v1}, 32'd0);
        end

        idle();
        step();
        chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
